sl_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing the slave output bus (sl_addr/sl_tail/sl_data) between up to
//  NUM_REQ bus_interface instances (EIN, GOC, PMU, ...). Each requester raises sl_arb_request,

---
 rtl/sl_bus_arbiter_pkg.sv | 10 +
 rtl/sl_bus_arbiter_if.sv | 16 +
 rtl/sl_bus_arbiter_rr_priority_pick.sv | 31 +++
 rtl/sl_bus_arbiter.sv | 73 +++++++
 tb/tb_sl_bus_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/sl_bus_arbiter_pkg.sv
// sl_bus_arbiter_pkg: shared state encodings and default sizes for the slave-bus arbiter
package sl_bus_arbiter_pkg;
  localparam int SL_ARB_NUM_REQ = 8;
  localparam int SL_ARB_ID_W = 3;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/sl_bus_arbiter_if.sv
// sl_bus_arbiter_if: request/grant bundle between requesters (slave) and the arbiter (master)
interface sl_bus_arbiter_if
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SL_ARB_NUM_REQ,
  parameter int ID_W = SL_ARB_ID_W
);
  logic [NUM_REQ-1:0] req;
  logic latch_tail;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic busy;
  logic timeout_err;
  modport master (input req, latch_tail, output grant, grant_id, busy, timeout_err);
  modport slave (output req, latch_tail, input grant, grant_id, busy, timeout_err);
endinterface

// File: rtl/sl_bus_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request bit scanning upward from rr_ptr with wraparound
module rr_priority_pick
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SL_ARB_NUM_REQ,
  parameter int ID_W = SL_ARB_ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    pick_id,
  output logic [NUM_REQ-1:0] pick_onehot
);
  int j;
  // scan from the farthest offset down so the nearest requester to rr_ptr wins
  always_comb begin
    found = 1'b0;
    pick_id = '0;
    pick_onehot = '0;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i >= NUM_REQ) ? int'(rr_ptr) + i - NUM_REQ : int'(rr_ptr) + i;
      if (req[j]) begin
        found = 1'b1;
        pick_id = ID_W'(j);
        pick_onehot = '0;
        pick_onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sl_bus_arbiter.sv
// sl_bus_arbiter: round-robin owner arbitration of the slave output bus (optional SL_ARB_TIMEOUT_EN)
module sl_bus_arbiter
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SL_ARB_NUM_REQ,
  parameter int ID_W = SL_ARB_ID_W
`ifdef SL_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input logic clk,
  input logic resetn,
  sl_bus_arbiter_if.master bus
);
  arb_state_e state, state_n;
  logic [NUM_REQ-1:0] grant_q, pick_oh;
  logic [ID_W-1:0] gid_q, rr_ptr, pick_id;
  logic found, terr_q, tmo, norm_rel, rel;
  rr_priority_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req(bus.req),
    .rr_ptr(rr_ptr),
    .found(found),
    .pick_id(pick_id),
    .pick_onehot(pick_oh)
  );
`ifdef SL_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;
  // hold counter sits at zero outside GRANT, so it starts from zero on every new grant
  always_ff @(posedge clk)
    hold_cnt <= (!resetn || state != ARB_GRANT) ? '0 : hold_cnt + 16'd1;
  assign tmo = state == ARB_GRANT && hold_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    state <= resetn ? state_n : ARB_IDLE;
  // next-state: grant on any request, release on tail/withdraw/timeout, one dead cycle
  always_comb
    case (state)
      ARB_IDLE:  state_n = found ? ARB_GRANT : ARB_IDLE;
      ARB_GRANT: state_n = rel ? ARB_RELEASE : ARB_GRANT;
      default:   state_n = ARB_IDLE;
    endcase
  // release decode; a normal release masks a coincident timeout
  always_comb begin
    norm_rel = state == ARB_GRANT && (bus.latch_tail || !(|(bus.req & grant_q)));
    rel = norm_rel || tmo;
  end
  // grant/owner/pointer registers
  always_ff @(posedge clk)
    if (!resetn) begin
      grant_q <= '0;
      gid_q <= '0;
      rr_ptr <= '0;
      terr_q <= 1'b0;
    end else begin
      terr_q <= tmo && !norm_rel;
      if (state == ARB_IDLE && found) begin
        grant_q <= pick_oh;
        gid_q <= pick_id;
      end
      if (rel) begin
        grant_q <= '0;
        rr_ptr <= (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
      end
    end
  assign bus.grant = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.busy = state == ARB_GRANT;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_sl_bus_arbiter.sv
// tb_sl_bus_arbiter: directed + random stimulus against an owner/turn-based reference model
module tb_sl_bus_arbiter;
  localparam int N = 8;
  localparam int W = 3;
`ifdef SL_ARB_TIMEOUT_EN
  localparam int TO = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 0;
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  sl_bus_arbiter_if #(.NUM_REQ(N), .ID_W(W)) bus ();
  sl_bus_arbiter #(
    .NUM_REQ(N),
    .ID_W(W)
`ifdef SL_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  int m_owner = -1;
  int m_gid = 0;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_dead = 1'b0;
  bit m_terr = 1'b0;
  logic [N-1:0] seq[$];
  logic [N-1:0] last, cur_req;
  logic [N-1:0] exp_rr[5] = '{8'h01, 8'h04, 8'h20, 8'h80, 8'h01};
  int cnt, pulses;
  bit rn, lt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(bit r_n, logic [N-1:0] r, bit l);
    bit norm, to;
    if (!r_n) begin
      m_owner = -1; m_gid = 0; m_ptr = 0; m_hold = 0; m_dead = 0; m_terr = 0;
      return;
    end
    m_terr = 0;
    if (m_dead) m_dead = 0;
    else if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_gid = m_owner;
          m_hold = 0;
          break;
        end
    end else begin
      norm = l || !r[m_owner];
      to = TO_EN && m_hold == TO - 1;
      if (norm || to) begin
        m_terr = to && !norm;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_dead = 1;
      end else m_hold++;
    end
  endtask

  task automatic cyc(bit r_n, logic [N-1:0] r, bit l);
    resetn = r_n;
    bus.req = r;
    bus.latch_tail = l;
    @(posedge clk);
    model(r_n, r, l);
    @(negedge clk);
    check("grant", bus.grant, m_owner < 0 ? 0 : 1 << m_owner);
    check("busy", bus.busy, m_owner >= 0);
    check("grant_id", bus.grant_id, m_gid);
    check("timeout_err", bus.timeout_err, m_terr);
  endtask

  task automatic rst();
    cyc(0, '0, 0);
    cyc(0, '0, 0);
  endtask

  initial begin
    bus.req = '0;
    bus.latch_tail = 1'b0;
    @(negedge clk);
    repeat (3) cyc(0, 8'hFF, 0);
    cyc(1, 8'hFF, 0);
    check("rst_first_grant", bus.grant, 8'h01);
    rst();
    last = '0;
    repeat (60) begin
      cyc(1, 8'hA5, m_owner >= 0 && m_hold == 2);
      if (bus.grant != 0 && last == 0) seq.push_back(bus.grant);
      last = bus.grant;
    end
    check("rr_count", seq.size() >= 5, 1);
    for (int i = 0; i < 5; i++) check("rr_order", i < seq.size() ? seq[i] : 0, exp_rr[i]);
    rst();
    cyc(1, 8'h02, 0);
    check("wd_grant", bus.grant, 8'h02);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h00, 0);
    check("wd_drop", bus.grant, 0);
    cyc(1, 8'h00, 0);
    cyc(1, 8'h02, 0);
    check("wd_regrant", bus.grant, 8'h02);
    cyc(1, 8'h00, 1);
    check("wd_both", bus.grant, 0);
    cyc(1, 8'hFF, 0);
    check("wd_dead", bus.busy, 0);
    cyc(1, 8'hFF, 0);
    check("wd_ptr", bus.grant, 8'h04);
    rst();
    cyc(1, 8'h08, 0);
    check("no_owner3", bus.grant, 8'h08);
    repeat (3) cyc(1, 8'h89, 0);
    check("no_hold", bus.grant, 8'h08);
    cyc(1, 8'h89, 1);
    cyc(1, 8'h81, 0);
    cyc(1, 8'h81, 0);
    check("no_next80", bus.grant, 8'h80);
    cyc(1, 8'h81, 1);
    cyc(1, 8'h81, 0);
    cyc(1, 8'h81, 0);
    check("no_next01", bus.grant, 8'h01);
    rst();
    cyc(1, 8'h20, 0);
    check("mr_owner5", bus.grant, 8'h20);
    cyc(0, 8'h20, 0);
    check("mr_drop", bus.grant, 0);
    cyc(1, 8'h21, 0);
    check("mr_first", bus.grant, 8'h01);
`ifdef SL_ARB_TIMEOUT_EN
    rst();
    cnt = 0;
    pulses = 0;
    cyc(1, 8'h01, 0);
    cnt += int'(bus.grant != 0);
    repeat (17) begin
      cyc(1, 8'h01, 0);
      cnt += int'(bus.grant != 0);
      pulses += int'(bus.timeout_err);
    end
    check("to_hold_len", cnt, 16);
    check("to_pulses", pulses, 1);
    rst();
    cyc(1, 8'h01, 0);
    repeat (14) cyc(1, 8'h01, 0);
    cyc(1, 8'h01, 1);
    check("to_norm_prio", bus.timeout_err, 0);
    check("to_norm_drop", bus.grant, 0);
`endif
    rst();
    cur_req = '0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) cur_req = N'($urandom);
      rn = $urandom_range(0, 199) != 0;
      lt = $urandom_range(0, 9) == 0;
      cyc(rn, cur_req, lt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
